// File: rtl/otter_muldiv_pkg.sv
// Shared types and constants for the OTTER iterative RV32M multiply/divide unit.
package otter_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    F3Mul    = 3'b000,
    F3Mulh   = 3'b001,
    F3Mulhsu = 3'b010,
    F3Mulhu  = 3'b011,
    F3Div    = 3'b100,
    F3Divu   = 3'b101,
    F3Rem    = 3'b110,
    F3Remu   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared radix-2 datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// {hi, lo} is the product, or remainder:quotient, after WIDTH steps.
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, m_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    div_d   = div_q;
    if (load) begin
      hi_d  = '0;
      div_d = div_mode;
      lo_d  = div_mode ? a_mag : b_mag;
      m_d   = div_mode ? b_mag : a_mag;
    end else if (step) begin
      if (div_q) begin
        // diff[WIDTH] is the borrow: set means remainder < divisor, so restore.
        if (!diff[WIDTH]) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
      div_q <= div_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/otter_muldiv.sv
// OTTER RV32M multiply/divide unit: FSM, sign handling and special-case forcing around
// the shared iterative core. Fixed latency regardless of operands.
module otter_muldiv
  import otter_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       FUNCT3,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  input  logic [4:0]       RD_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             WE,
  output logic [WIDTH-1:0] RESULT,
  output logic [4:0]       RD_OUT
);

  localparam int unsigned CntW = (WIDTH == XLEN) ? CNT_W : $clog2(WIDTH);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 load, step;
  funct3_e              f3_in, op_q;
  logic                 signed_a, signed_b, sa, sb;
  logic [WIDTH-1:0]     a_mag, b_mag, a_q, result_q, result_d;
  logic [4:0]           rd_q;
  logic                 neg_q, dbz_q, ovf_q;
  logic [WIDTH-1:0]     hi, lo, quot_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod, prod_fix;

  assign f3_in = funct3_e'(FUNCT3);

  always_comb begin
    signed_a = f3_in inside {F3Mulh, F3Mulhsu, F3Div, F3Rem};
    signed_b = f3_in inside {F3Mulh, F3Div, F3Rem};
    sa       = signed_a & OP_A[WIDTH-1];
    sb       = signed_b & OP_B[WIDTH-1];
    a_mag    = sa ? -OP_A : OP_A;
    b_mag    = sb ? -OP_B : OP_B;
  end

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (load),
    .step    (step),
    .div_mode(FUNCT3[2]),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .hi      (hi),
    .lo      (lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StFix;
        end
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -lo : lo;
    rem_fix  = neg_q ? -hi : hi;
    result_d = result_q;
    unique case (op_q)
      F3Mul:                     result_d = prod_fix[WIDTH-1:0];
      F3Mulh, F3Mulhsu, F3Mulhu: result_d = prod_fix[2*WIDTH-1:WIDTH];
      F3Div, F3Divu: result_d = dbz_q ? '1 : (ovf_q ? {1'b1, {(WIDTH-1){1'b0}}} : quot_fix);
      F3Rem, F3Remu: result_d = dbz_q ? a_q : (ovf_q ? '0 : rem_fix);
      default:       result_d = result_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= F3Mul;
      rd_q     <= '0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q  <= f3_in;
        rd_q  <= RD_IN;
        a_q   <= OP_A;
        // Remainder follows the dividend sign; everything else the sign product.
        neg_q <= (f3_in inside {F3Rem, F3Remu}) ? sa : (sa ^ sb);
        dbz_q <= (OP_B == '0);
        ovf_q <= (f3_in inside {F3Div, F3Rem}) && (OP_A == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (OP_B == '1);
      end
      if (state_q == StFix) result_q <= result_d;
    end
  end

  assign BUSY   = (state_q != StIdle);
  assign DONE   = (state_q == StDone);
  assign WE     = DONE;
  assign RESULT = result_q;
  assign RD_OUT = rd_q;

endmodule

// File: tb/tb_otter_muldiv.sv
// Bench for otter_muldiv: arithmetic/timing reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_otter_muldiv;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          START = 1'b0;
  logic [2:0]    FUNCT3 = '0;
  logic [W-1:0]  OP_A = '0;
  logic [W-1:0]  OP_B = '0;
  logic [4:0]    RD_IN = '0;
  logic          BUSY, DONE, WE;
  logic [W-1:0]  RESULT;
  logic [4:0]    RD_OUT;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  otter_muldiv #(
    .WIDTH(W)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .FUNCT3(FUNCT3),
    .OP_A  (OP_A),
    .OP_B  (OP_B),
    .RD_IN (RD_IN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .WE    (WE),
    .RESULT(RESULT),
    .RD_OUT(RD_OUT)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // RV32M semantics from native arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int ai, bi;
    ai = a;
    bi = b;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'(ai) * longint'(bi); return p[63:32]; end
      3'd2: begin p = longint'(ai) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ai / bi;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ai % bi;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Timing model: accepted at edge k, result and DONE after edge k+W+1, idle after k+W+2.
  logic        m_active = 1'b0;
  int          m_age = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_res    <= '0;
      m_rd     <= '0;
    end else if (m_active) begin
      m_age <= m_age + 1;
      if (m_age + 1 == W + 1) m_res <= m_pend;
      if (m_age + 1 == W + 2) m_active <= 1'b0;
    end else if (START) begin
      m_active <= 1'b1;
      m_age    <= 0;
      m_rd     <= RD_IN;
      m_pend   <= model(FUNCT3, OP_A, OP_B);
    end
  end

  always @(negedge CLK) begin
    logic exp_done;
    exp_done = m_active && (m_age == W + 1);
    check("busy", {31'b0, BUSY}, {31'b0, m_active});
    check("done", {31'b0, DONE}, {31'b0, exp_done});
    check("we", {31'b0, WE}, {31'b0, exp_done});
    check("result", RESULT, m_res);
    check("rd_out", {27'b0, RD_OUT}, {27'b0, m_rd});
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(posedge CLK);
    #1;
    START  = 1'b1;
    FUNCT3 = f;
    OP_A   = a;
    OP_B   = b;
    RD_IN  = rd;
    @(posedge CLK);
    #1;
    START  = 1'b0;
    FUNCT3 = 3'($urandom);
    OP_A   = $urandom;
    OP_B   = $urandom;
    RD_IN  = 5'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int n;
    check({name, " model"}, model(f, a, b), exp);
    issue(f, a, b, rd);
    wait_done(n);
    check({name, " latency"}, n, W + 1);
    check({name, " result"}, RESULT, exp);
    check({name, " rd"}, {27'b0, RD_OUT}, {27'b0, rd});
    check({name, " we"}, {31'b0, WE}, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n, nd;
    #1 RST_N = 1'b0;
    #1;
    check("rst busy", {31'b0, BUSY}, 32'd0);
    check("rst done", {31'b0, DONE}, 32'd0);
    check("rst result", RESULT, 32'd0);
    check("rst rd", {27'b0, RD_OUT}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    run_vec("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
    run_vec("mulh", 3'd1, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000);
    run_vec("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE);
    run_vec("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 5'd8, 32'hFFFFFFFF);
    run_vec("div neg", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD);
    run_vec("rem neg", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF);
    run_vec("div negb", 3'd4, 32'd7, 32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD);
    run_vec("rem negb", 3'd6, 32'd7, 32'hFFFFFFFE, 5'd12, 32'd1);
    run_vec("divu", 3'd5, 32'd100, 32'd7, 5'd13, 32'd14);
    run_vec("remu", 3'd7, 32'd100, 32'd7, 5'd14, 32'd2);
    run_vec("divu by0", 3'd5, 32'h1234, 32'd0, 5'd15, 32'hFFFFFFFF);
    run_vec("remu by0", 3'd7, 32'h1234, 32'd0, 5'd16, 32'h1234);
    run_vec("div by0", 3'd4, 32'h80000000, 32'd0, 5'd17, 32'hFFFFFFFF);
    run_vec("rem by0", 3'd6, 32'hFFFFFFFB, 32'd0, 5'd18, 32'hFFFFFFFB);
    run_vec("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000);
    run_vec("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h0);
    run_vec("mul x0", 3'd0, 32'h00010001, 32'h00010001, 5'd0, 32'h00020001);

    // START pulses while busy must be dropped.
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      START = (i == 5 || i == 20);
      if (START) begin
        FUNCT3 = 3'd4;
        OP_A   = 32'd50;
        OP_B   = 32'd3;
        RD_IN  = 5'd17;
      end
      if (DONE) begin
        n = i;
        break;
      end
    end
    START = 1'b0;
    check("ignore latency", n, W + 1);
    check("ignore result", RESULT, 32'hFFFFFFEB);
    check("ignore rd", {27'b0, RD_OUT}, 32'd5);

    // Back-to-back: issue in the idle cycle right after DONE.
    @(posedge CLK);
    #1;
    check("b2b idle", {31'b0, BUSY}, 32'd0);
    START  = 1'b1;
    FUNCT3 = 3'd5;
    OP_A   = 32'd100;
    OP_B   = 32'd7;
    RD_IN  = 5'd12;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("b2b busy", {31'b0, BUSY}, 32'd1);
    wait_done(n);
    check("b2b latency", n, W + 1);
    check("b2b result", RESULT, 32'd14);
    check("b2b rd", {27'b0, RD_OUT}, 32'd12);
    @(posedge CLK);
    #1;

    // Asynchronous reset mid-calculation.
    issue(3'd7, 32'd100, 32'd7, 5'd9);
    repeat (10) @(posedge CLK);
    #1;
    check("pre-rst busy", {31'b0, BUSY}, 32'd1);
    #1 RST_N = 1'b0;
    #1;
    check("mid-rst busy", {31'b0, BUSY}, 32'd0);
    check("mid-rst done", {31'b0, DONE}, 32'd0);
    check("mid-rst we", {31'b0, WE}, 32'd0);
    check("mid-rst result", RESULT, 32'd0);
    check("mid-rst rd", {27'b0, RD_OUT}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (DONE) nd++;
    end
    check("no done after rst", nd, 32'd0);
    run_vec("post-rst remu", 3'd7, 32'd100, 32'd7, 5'd21, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
